// File: rtl/ycr_mul_arb_if.sv
// Request/response and multiplier-side bundle for ycr_mul_arb.
// The slave modport is the arbiter; master is its environment.
interface ycr_mul_arb_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [2*NREQ-1:0]  req_op_i;
    logic [32*NREQ-1:0] req_src1_i;
    logic [32*NREQ-1:0] req_src2_i;
    logic [NREQ-1:0]    rsp_valid_o;
    logic [NREQ-1:0]    rsp_ready_i;
    logic [31:0]        rsp_data_o;
    logic               rsp_err_o;
    logic               mul_valid_o;
    logic [32:0]        mul_din1_o;
    logic [32:0]        mul_din2_o;
    logic [31:0]        mul_hig_i;
    logic [31:0]        mul_low_i;
    logic               mul_rdy_i;
    logic               mul_done_o;

    modport slave (
        input  req_valid_i, req_op_i, req_src1_i, req_src2_i,
        input  rsp_ready_i, mul_hig_i, mul_low_i, mul_rdy_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output mul_valid_o, mul_din1_o, mul_din2_o, mul_done_o
    );

    modport master (
        output req_valid_i, req_op_i, req_src1_i, req_src2_i,
        output rsp_ready_i, mul_hig_i, mul_low_i, mul_rdy_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  mul_valid_o, mul_din1_o, mul_din2_o, mul_done_o
    );
endinterface

// File: rtl/ycr_mul_arb.sv
// Round-robin arbiter sharing one pipelined 32x32 multiplier
// between NREQ M-extension requesters, with a completion watchdog.
module ycr_mul_arb #(
    parameter int NREQ    = 2,
    parameter int TMO_CYC = 63
) (
    input logic          clk,
    input logic          rstn,
    ycr_mul_arb_if.slave io
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     src1_q, src1_d;
    logic [31:0]     src2_q, src2_d;
    logic [31:0]     data_q, data_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [IW-1:0]   win;
    logic            found;
    logic [NREQ-1:0] win_oh;
    logic [NREQ-1:0] gnt_oh;

    // Search starts one past the last served requester.
    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(last_q) + i) % NREQ;
            if (!found && io.req_valid_i[k]) begin
                found = 1'b1;
                win   = IW'(k);
            end
        end
    end

    assign win_oh = found ? (NREQ'(1) << win) : '0;
    assign gnt_oh = NREQ'(1) << gnt_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    op_d    = io.req_op_i[2*win +: 2];
                    src1_d  = io.req_src1_i[32*win +: 32];
                    src2_d  = io.req_src2_i[32*win +: 32];
                    gnt_d   = win;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (io.mul_rdy_i) begin
                    data_d  = (op_q == OP_MUL) ? io.mul_low_i
                                               : io.mul_hig_i;
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_RESP;
                end else if (cnt_d == 8'(TMO_CYC)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (io.rsp_ready_i[gnt_q]) begin
                    last_d  = gnt_q;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NREQ - 1);
            gnt_q   <= '0;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sign bits come straight from the held operands; the
    // multiplier reads them late, so they must not move.
    assign io.mul_din1_o = {((op_q == OP_MULH) || (op_q == OP_MULHSU))
                            & src1_q[31], src1_q};
    assign io.mul_din2_o = {(op_q == OP_MULH) & src2_q[31], src2_q};

    assign io.req_ready_o = (state_q == S_IDLE) ? win_oh : '0;
    assign io.mul_valid_o = (state_q == S_ISSUE);
    assign io.rsp_valid_o = (state_q == S_RESP) ? gnt_oh : '0;
    assign io.rsp_data_o  = data_q;
    assign io.rsp_err_o   = err_q;
    assign io.mul_done_o  = done_q;

endmodule

// File: tb/tb_ycr_mul_arb.sv
// Directed bench for ycr_mul_arb with a behavioural
// pipelined multiplier stub (ready 11 cycles after valid).
module tb_ycr_mul_arb;
    localparam int NREQ = 2;
    localparam int TMO  = 63;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic stuck = 1'b0;
    int   cyc  = 0;
    int   nchk = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ycr_mul_arb_if #(.NREQ(NREQ)) bus ();

    ycr_mul_arb #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
        .clk (clk),
        .rstn(rstn),
        .io  (bus.slave)
    );

    // Multiplier stub: rdy in the 11th cycle after valid is sampled,
    // held until done.
    logic [3:0]         mcnt;
    logic signed [65:0] prod;

    always @(posedge clk or negedge rstn) begin
        if (!rstn)                           mcnt <= 4'd0;
        else if (bus.mul_done_o)             mcnt <= 4'd0;
        else if (bus.mul_valid_o && !stuck)  mcnt <= 4'd1;
        else if (mcnt != 4'd0 && mcnt != 4'd11) mcnt <= mcnt + 4'd1;
    end

    assign prod = $signed({{33{bus.mul_din1_o[32]}}, bus.mul_din1_o})
                * $signed({{33{bus.mul_din2_o[32]}}, bus.mul_din2_o});
    assign bus.mul_rdy_i = (mcnt == 4'd11);
    assign bus.mul_hig_i = prod[63:32];
    assign bus.mul_low_i = prod[31:0];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int r, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bus.req_valid_i[r]       = 1'b1;
        bus.req_op_i[2*r +: 2]   = op;
        bus.req_src1_i[32*r +: 32] = a;
        bus.req_src2_i[32*r +: 32] = b;
    endtask

    task automatic acc(input int r, input bit drop, input string tag,
                       output int a);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.req_ready_o != '0) break;
            @(negedge clk);
        end
        chk({tag, "_gnt"}, 64'(bus.req_ready_o), 64'(1) << r);
        a = cyc;
        @(negedge clk);
        if (drop) bus.req_valid_i[r] = 1'b0;
    endtask

    task automatic rsp(input int r, input logic [31:0] d, input logic e,
                       input int hold, input string tag, output int t);
        for (int i = 0; i < 200; i++) begin
            if (bus.rsp_valid_o != '0) break;
            @(negedge clk);
        end
        t = cyc;
        chk({tag, "_vld"}, 64'(bus.rsp_valid_o), 64'(1) << r);
        chk({tag, "_dat"}, 64'(bus.rsp_data_o), 64'(d));
        chk({tag, "_err"}, 64'(bus.rsp_err_o), 64'(e));
        chk({tag, "_done1"}, 64'(bus.mul_done_o), 64'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk({tag, "_hdat"}, 64'(bus.rsp_data_o), 64'(d));
            chk({tag, "_hvld"}, 64'(bus.rsp_valid_o), 64'(1) << r);
            chk({tag, "_hrdy"}, 64'(bus.req_ready_o), 64'(0));
        end
        bus.rsp_ready_i[r] = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i[r] = 1'b0;
        chk({tag, "_done0"}, 64'(bus.mul_done_o), 64'(0));
    endtask

    task automatic op1(input int r, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input string tag);
        int ta, tr;
        drive(r, op, a, b);
        acc(r, 1'b1, tag, ta);
        rsp(r, d, 1'b0, 0, tag, tr);
        chk({tag, "_lat"}, 64'(tr - ta), 64'(13));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_d1"}, 64'(bus.mul_din1_o), 64'(0));
        chk({tag, "_d2"}, 64'(bus.mul_din2_o), 64'(0));
        chk({tag, "_dat"}, 64'(bus.rsp_data_o), 64'(0));
        chk({tag, "_ctl"}, 64'({bus.req_ready_o, bus.rsp_valid_o,
            bus.rsp_err_o, bus.mul_valid_o, bus.mul_done_o}), 64'(0));
    endtask

    initial begin
        int ta, tr, ti;
        logic [31:0] pa;
        int n0, n1, r;
        bus.req_valid_i = '0;
        bus.req_op_i    = '0;
        bus.req_src1_i  = '0;
        bus.req_src2_i  = '0;
        bus.rsp_ready_i = '0;

        repeat (2) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        op1(0, 2'b00, 32'd7, 32'd6, 32'h0000002A, "mul7x6");
        op1(0, 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, "mulh");
        op1(0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        op1(0, 2'b00, 32'h80000000, 32'h80000000, 32'h0, "mulmin");
        op1(1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");

        // Both requesters held valid; expected 0,1,0,1.
        n0 = 0;
        n1 = 0;
        drive(0, 2'b00, 32'd3, 32'd5);
        drive(1, 2'b00, 32'd100, 32'd7);
        for (int k = 0; k < 4; k++) begin
            r = k % 2;
            acc(r, 1'b0, "rr", ta);
            if (r == 0) begin
                pa = 32'(3 + n0) * 32'd5;
                n0++;
                drive(0, 2'b00, 32'(3 + n0), 32'd5);
            end else begin
                pa = 32'(100 + n1) * 32'd7;
                n1++;
                drive(1, 2'b00, 32'(100 + n1), 32'd7);
            end
            if (k == 3) bus.req_valid_i = '0;
            rsp(r, pa, 1'b0, 0, "rr", tr);
            chk("rr_lat", 64'(tr - ta), 64'(13));
        end

        // Response stall with a competing request pending.
        drive(0, 2'b00, 32'h00012345, 32'h10);
        acc(0, 1'b1, "stall", ta);
        drive(1, 2'b00, 32'd9, 32'd9);
        rsp(0, 32'h00123450, 1'b0, 5, "stall", tr);
        acc(1, 1'b1, "stall_nxt", ti);
        chk("stall_acc", 64'(ti - tr), 64'(6));
        rsp(1, 32'd81, 1'b0, 0, "stall_nxt", tr);

        // Watchdog with a stuck multiplier.
        stuck = 1'b1;
        drive(0, 2'b00, 32'd2, 32'd3);
        acc(0, 1'b1, "tmo", ta);
        chk("tmo_issue", 64'(bus.mul_valid_o), 64'(1));
        ti = cyc;
        rsp(0, 32'h0, 1'b1, 0, "tmo", tr);
        chk("tmo_lat", 64'(tr - ti), 64'(TMO + 1));
        stuck = 1'b0;
        op1(0, 2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, "posttmo");

        // Asynchronous reset during WAIT.
        drive(0, 2'b01, 32'h80000000, 32'h80000001);
        acc(0, 1'b1, "rst", ta);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        op1(1, 2'b00, 32'd9, 32'd9, 32'd81, "r1only");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=done", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ycr_mul_arb.md
# ycr_mul_arb

Round-robin arbiter and sequencer that shares one `ycr_pipe_mul` 32x32 multiplier between NREQ requesters. It accepts RISC-V M-extension multiply requests (MUL/MULH/MULHSU/MULHU) and sign-extends the operands to the multiplier's 33-bit format. It drives the multiplier's valid/ready/done handshake, selects the high or low result word, and returns it over a per-requester valid/ready response channel. A watchdog ends any operation the multiplier never completes.

## Interface
- NREQ, 2, number of requesters (1..4)
- TMO_CYC, 63, WAIT-state cycles before the watchdog fires (1..255)

- clk  in  1  core clock
- rstn  in  1  reset; asynchronous, active-low
- req_valid_i  in  NREQ  request valid, one bit per requester
- req_ready_o  out  NREQ  request accepted (one-hot pulse)
- req_op_i  in  2*NREQ  op per requester: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_src1_i / req_src2_i  in  32*NREQ  operands per requester
- rsp_valid_o  out  NREQ  response valid, one-hot to the granted requester
- rsp_ready_i  in  NREQ  response taken
- rsp_data_o  out  32  result word
- rsp_err_o  out  1  watchdog fired for this response
- mul_valid_o  out  1  to multiplier `data_valid`
- mul_din1_o / mul_din2_o  out  33  to `Din1`/`Din2`; bit 32 = sign
- mul_hig_i / mul_low_i  in  32  from `des_hig`/`des_low`
- mul_rdy_i  in  1  from `mul_rdy_o`
- mul_done_o  out  1  to `data_done`

## Operation
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid_i is high, pick the winner round-robin, starting the search at last_grant+1 (mod NREQ).
  - Assert req_ready_o[winner] combinationally in this cycle.
  - Latch op, src1 and src2 into operand registers, and the winner index into gnt.
  - Go to ISSUE.
- Operand extension, from the latched op:
  - din1[32] = src1[31] for MULH and MULHSU, else 0.
  - din2[32] = src2[31] for MULH only, else 0.
  - mul_din1_o/mul_din2_o are driven from the operand registers. They stay stable from ISSUE until the return to IDLE, because the multiplier samples the sign bits late in the operation.
- ISSUE: mul_valid_o = 1 for exactly one cycle; clear the watchdog counter; go to WAIT.
- WAIT: the watchdog counter increments each cycle.
  - If mul_rdy_i = 1: capture rsp_data = (op==MUL) ? mul_low_i : mul_hig_i; rsp_err = 0; go to RESP.
  - Else, if the counter reaches TMO_CYC: capture rsp_data = 0; rsp_err = 1; go to RESP.
  - mul_rdy_i has priority over the timeout when both occur in the same cycle.
- RESP:
  - mul_done_o is a registered pulse, high only in the first RESP cycle.
  - rsp_valid_o[gnt] = 1; rsp_data_o and rsp_err_o are held until rsp_ready_i[gnt] = 1.
  - On that handshake: last_grant <= gnt; go to IDLE.
- No new request is granted outside IDLE. Requesters hold req_valid_i and its payload until req_ready_o.
- rsp_ready_i bits of non-granted requesters are ignored.
- Reset values:
  - state IDLE; last_grant = NREQ-1, so requester 0 wins first.
  - All outputs are 0, including operand registers, rsp_data_o and rsp_err_o.
- Reset mid-operation returns to IDLE immediately; any in-flight response is discarded. The multiplier shares rstn.

## Timing
- Accept cycle = A (IDLE, req_ready_o high). mul_valid_o is high in cycle A+1.
- With `ycr_pipe_mul` (mul_rdy_o rises 11 cycles after data_valid is sampled):
  - mul_rdy_i is high in cycle A+12.
  - rsp_valid_o and mul_done_o are high in cycle A+13.
- If rsp_ready_i is already high in A+13, the next accept can occur in A+14. Minimum issue interval is 14 cycles.
- With the multiplier stuck, the watchdog fires TMO_CYC cycles after entering WAIT; rsp_valid_o rises one cycle later.
- rsp_valid_o never de-asserts before its handshake. rsp_data_o/rsp_err_o never change while rsp_valid_o is high.

## Test plan
- MUL, requester 0, 7 x 6 -> rsp_data_o = 0x0000002A; rsp_err_o = 0; rsp_valid_o rises exactly 13 cycles after req_ready_o; mul_done_o is a single-cycle pulse.
- MULH 0xFFFFFFFD x 0x00000005 -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MUL 0x80000000 x 0x80000000 -> 0x00000000.
- Both requesters hold req_valid_i continuously for 4 ops -> grant order 0,1,0,1. Each rsp_data_o matches its own operands; rsp_valid_o is one-hot to the correct index.
- rsp_ready_i held low for 5 cycles in RESP -> rsp_data_o stable throughout; no req_ready_o pulses; accept happens the cycle after the handshake.
- Multiplier stub with mul_rdy_i tied 0 -> rsp_valid_o with rsp_err_o = 1 and rsp_data_o = 0 exactly TMO_CYC+1 cycles after ISSUE. A following request with a real multiplier completes normally with rsp_err_o = 0.
- rstn pulsed low during WAIT -> all outputs 0 asynchronously. After release, a requester-1-only request is granted and completes correctly.
